// File: rtl/target_reset_scheduler.sv
// Power-cycle scheduler: arbitrates host, watchdog and optional periodic requests into trigger pulses.
// Latency: a pending request seen in IDLE with throttle low fires trigger on the next cycle.
// Backpressure: target_throttle high holds the FSM; requests stay pending and are coalesced.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   host_req           pulse, request one power cycle
//   wd_en, heartbeat   watchdog arm level / heartbeat pulse from target
//   period_en          periodic campaign enable (only with TARGET_SCHED_PERIODIC_EN)
//   target_throttle    high while target_control_power is cycling
//   err_clr            pulse, clears err_no_response
//   trigger, host_ack  1-cycle pulses in the FIRE cycle
//   cause              last fired cause: 0 none, 1 host, 2 watchdog, 3 periodic
//   cycle_count        saturating count of fired cycles
//   busy               high whenever the FSM is not IDLE
//   err_no_response    sticky, throttle failed to rise after a trigger
// Optional feature macro: TARGET_SCHED_PERIODIC_EN (periodic campaign counter).

module target_reset_scheduler #(
    parameter int WATCHDOG_CYCLES = 1000,
    parameter int SETTLE_CYCLES   = 4,
    parameter int HOLDOFF_CYCLES  = 16,
    parameter int PERIOD_CYCLES   = 256,
    parameter int COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_req,
    input  logic               wd_en,
    input  logic               heartbeat,
    input  logic               period_en,
    input  logic               target_throttle,
    input  logic               err_clr,
    output logic               trigger,
    output logic               host_ack,
    output logic [1:0]         cause,
    output logic [COUNT_W-1:0] cycle_count,
    output logic               busy,
    output logic               err_no_response
);

    localparam int TMR_MAX = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int WD_W    = $clog2(WATCHDOG_CYCLES + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLDOFF_LAST = TMR_W'(HOLDOFF_CYCLES - 1);
    // Terminal compare one below WATCHDOG_CYCLES-1 so that the counter "reaching"
    // WATCHDOG_CYCLES-1 and the pending flag rising happen on the same edge.
    localparam logic [WD_W-1:0]  WD_TERM      = WD_W'(WATCHDOG_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_BUSY,
        WAIT_DONE,
        HOLDOFF
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic             host_pend;
    logic             wd_pend;
    logic             per_pend;
    logic [WD_W-1:0]  wd_cnt;
    logic             go;
    logic             err_set;

    assign go      = (state == IDLE) && (host_pend || wd_pend || per_pend) && !target_throttle;
    assign err_set = (state == WAIT_BUSY) && !target_throttle && (tmr == SETTLE_LAST);

    // Main sequencer; all outputs registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tmr             <= '0;
            trigger         <= 1'b0;
            host_ack        <= 1'b0;
            cause           <= 2'd0;
            cycle_count     <= '0;
            busy            <= 1'b0;
            err_no_response <= 1'b0;
        end else begin
            trigger  <= 1'b0;
            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= FIRE;
                        busy     <= 1'b1;
                        trigger  <= 1'b1;
                        host_ack <= host_pend;
                        cause    <= host_pend ? 2'd1 : (wd_pend ? 2'd2 : 2'd3);
                        if (cycle_count != '1) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    state <= WAIT_BUSY;
                    tmr   <= '0;
                end
                WAIT_BUSY: begin
                    if (target_throttle) begin
                        state <= WAIT_DONE;
                    end else if (tmr == SETTLE_LAST) begin
                        state <= HOLDOFF;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!target_throttle) begin
                        state <= HOLDOFF;
                        tmr   <= '0;
                    end
                end
                HOLDOFF: begin
                    if (tmr == HOLDOFF_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A fresh timeout beats a same-cycle clear.
            if (err_set) begin
                err_no_response <= 1'b1;
            end else if (err_clr) begin
                err_no_response <= 1'b0;
            end
        end
    end

    // Host request: a new request beats the FIRE-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_pend <= 1'b0;
        end else if (host_req) begin
            host_pend <= 1'b1;
        end else if (state == FIRE) begin
            host_pend <= 1'b0;
        end
    end

    // Watchdog: counts IDLE cycles without heartbeat, paused while the target is busy externally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            wd_pend <= 1'b0;
        end else if (!wd_en) begin
            wd_cnt  <= '0;
            wd_pend <= 1'b0;
        end else begin
            if (state == FIRE) begin
                wd_pend <= 1'b0;
            end
            if (state != IDLE || heartbeat) begin
                wd_cnt <= '0;
            end else if (!target_throttle) begin
                if (wd_cnt == WD_TERM) begin
                    wd_pend <= 1'b1;
                    wd_cnt  <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

`ifdef TARGET_SCHED_PERIODIC_EN
    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam logic [PER_W-1:0] PER_TERM = PER_W'(PERIOD_CYCLES - 2);

    logic [PER_W-1:0] per_cnt;

    // Periodic campaign: same counting rules as the watchdog, without heartbeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt  <= '0;
            per_pend <= 1'b0;
        end else if (!period_en) begin
            per_cnt  <= '0;
            per_pend <= 1'b0;
        end else begin
            if (state == FIRE) begin
                per_pend <= 1'b0;
            end
            if (state != IDLE) begin
                per_cnt <= '0;
            end else if (!target_throttle) begin
                if (per_cnt == PER_TERM) begin
                    per_pend <= 1'b1;
                    per_cnt  <= '0;
                end else begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_period;

    assign per_pend      = 1'b0;
    assign unused_period = period_en ^ (PERIOD_CYCLES == 0);
`endif

endmodule

// File: tb/tb_target_reset_scheduler.sv
// Bench for target_reset_scheduler: scoreboard of expected trigger events plus direct checks.
// Latency: expected trigger cycles are computed from request timing and pushed with the stimulus.
// Backpressure: a small model of target_control_power drives target_throttle after each trigger.

module tb_target_reset_scheduler;

    localparam int WD   = 20;
    localparam int SET  = 4;
    localparam int HOLD = 16;
    localparam int PER  = 32;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req;
    logic          wd_en;
    logic          heartbeat;
    logic          period_en;
    logic          target_throttle;
    logic          err_clr;
    logic          trigger;
    logic          host_ack;
    logic [1:0]    cause;
    logic [CW-1:0] cycle_count;
    logic          busy;
    logic          err_no_response;

    logic thr_model = 1'b0;
    logic thr_ext   = 1'b0;
    int   thr_len   = 13;

    assign target_throttle = thr_model | thr_ext;

    target_reset_scheduler #(
        .WATCHDOG_CYCLES(WD),
        .SETTLE_CYCLES  (SET),
        .HOLDOFF_CYCLES (HOLD),
        .PERIOD_CYCLES  (PER),
        .COUNT_W        (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_req       (host_req),
        .wd_en          (wd_en),
        .heartbeat      (heartbeat),
        .period_en      (period_en),
        .target_throttle(target_throttle),
        .err_clr        (err_clr),
        .trigger        (trigger),
        .host_ack       (host_ack),
        .cause          (cause),
        .cycle_count    (cycle_count),
        .busy           (busy),
        .err_no_response(err_no_response)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  cause;
        logic        ack;
        logic [1:0]  cnt;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_trig    = 0;
    int   last_trig = 0;
    int   exp_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic a, input int at);
        exp_t e;
        if (exp_cnt < CMAX) exp_cnt++;
        e.cause = c;
        e.ack   = a;
        e.cnt   = 2'(exp_cnt);
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic goto(input int target);
        int k = 0;
        while (cyc < target && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic wait_ntrig(input int target);
        int k = 0;
        while (n_trig < target && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (n_trig < target) chk("trigger_timeout", n_trig, target);
    endtask

    task automatic wait_idle(output int at);
        int k = 0;
        while (busy && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) chk("idle_timeout", busy, 0);
        at = cyc;
    endtask

    task automatic host_pulse();
        host_req = 1'b1;
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    // Scoreboard side: every trigger pops one expectation.
    always @(negedge clk) begin
        if (!rst && trigger) begin
            exp_t e;
            n_trig++;
            last_trig = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_trigger", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("trig_cycle", cyc, e.cyc);
                chk("trig_cause", cause, e.cause);
                chk("trig_host_ack", host_ack, e.ack);
                chk("trig_count", cycle_count, e.cnt);
            end
        end
    end

    // Model of target_control_power: throttle rises the cycle after trigger, stays thr_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (trigger && thr_len != 0) begin
                @(posedge clk); #1 thr_model = 1'b1;
                repeat (thr_len) @(posedge clk);
                #1 thr_model = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, t, i, n0;

        rst = 1'b1; host_req = 1'b0; wd_en = 1'b0; heartbeat = 1'b0;
        period_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_trigger", trigger, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_cause", cause, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_no_response, 0);
        rst = 1'b0;
        exp_cnt = 0;
        repeat (3) @(posedge clk);
        #1;

        // 1: host request, 13-cycle throttle; busy spans throttle + holdoff + 2.
        thr_len = 13;
        c = cyc;
        push(2'd1, 1'b1, c + 2);
        host_pulse();
        wait_ntrig(1);
        t = c + 2;
        wait_idle(i);
        chk("t1_busy_len", i - t, 13 + HOLD + 2);
        chk("t1_cause_hold", cause, 1);

        // 2: watchdog with no heartbeat fires WD cycles after arming in IDLE.
        thr_len = 3;
        c = cyc;
        wd_en = 1'b1;
        push(2'd2, 1'b0, c + WD);
        wait_ntrig(2);
        wait_idle(i);

        // 3: host request on the watchdog terminal edge: one fire, host cause.
        goto(i + WD - 2);
        push(2'd1, 1'b1, i + WD);
        host_pulse();
        wait_ntrig(3);
        wait_idle(i);
        wd_en = 1'b0;
        goto(i + 15);

        // Heartbeats every 13 cycles keep the watchdog quiet.
        n0 = n_trig;
        wd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            goto(cyc + 12);
            heartbeat = 1'b1;
            @(posedge clk); #1;
            heartbeat = 1'b0;
        end
        wd_en = 1'b0;
        chk("hb_no_fire", n_trig - n0, 0);

        // 4: requests in WAIT_DONE and HOLDOFF coalesce into one fire after HOLDOFF.
        thr_len = 13;
        n0 = n_trig;
        c = cyc;
        push(2'd1, 1'b1, c + 2);
        host_pulse();
        t = c + 2;
        goto(t + 5);
        push(2'd1, 1'b1, t + 13 + HOLD + 3);
        host_pulse();
        goto(t + 20);
        host_pulse();
        wait_ntrig(n0 + 2);
        wait_idle(i);
        goto(i + 20);
        chk("t4_count_sat", cycle_count, CMAX);

        // 5: no throttle response sets the sticky error SET+1 cycles after trigger.
        thr_len = 0;
        n0 = n_trig;
        c = cyc;
        push(2'd1, 1'b1, c + 2);
        host_pulse();
        t = c + 2;
        goto(t + SET);
        chk("t5_err_early", err_no_response, 0);
        goto(t + SET + 1);
        chk("t5_err_set", err_no_response, 1);
        wait_idle(i);
        chk("t5_err_sticky", err_no_response, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t5_err_clr", err_no_response, 0);

        // External throttle in IDLE holds a pending request.
        thr_len = 3;
        n0 = n_trig;
        thr_ext = 1'b1;
        host_pulse();
        goto(cyc + 10);
        chk("ext_hold", n_trig - n0, 0);
        push(2'd1, 1'b1, cyc + 1);
        thr_ext = 1'b0;
        wait_ntrig(n0 + 1);
        wait_idle(i);

        // 6: async reset in WAIT_DONE clears outputs within the cycle.
        thr_len = 13;
        n0 = n_trig;
        c = cyc;
        push(2'd1, 1'b1, c + 2);
        host_pulse();
        t = c + 2;
        goto(t + 6);
        rst = 1'b1;
        #1;
        chk("t6_rst_trigger", trigger, 0);
        chk("t6_rst_ack", host_ack, 0);
        chk("t6_rst_cause", cause, 0);
        chk("t6_rst_count", cycle_count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err_no_response, 0);
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        goto(t + 20);
        n0 = n_trig;
        c = cyc;
        push(2'd1, 1'b1, c + 2);
        host_pulse();
        wait_ntrig(n0 + 1);
        wait_idle(i);

`ifdef TARGET_SCHED_PERIODIC_EN
        // 7: periodic campaign, spacing = cycle time + PER.
        thr_len = 3;
        n0 = n_trig;
        c = cyc;
        period_en = 1'b1;
        push(2'd3, 1'b0, c + PER);
        wait_ntrig(n0 + 1);
        t = last_trig;
        push(2'd3, 1'b0, t + 3 + HOLD + 2 + PER);
        wait_ntrig(n0 + 2);
        period_en = 1'b0;
        wait_idle(i);
        goto(i + 40);
        chk("t7_stop", n_trig - n0, 2);
`else
        // Without the periodic feature period_en has no effect.
        n0 = n_trig;
        period_en = 1'b1;
        goto(cyc + 80);
        period_en = 1'b0;
        chk("no_periodic", n_trig - n0, 0);
`endif

        goto(cyc + 30);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
